// File: rtl/mmio_uart_pkg.sv
// Shared definitions for the memory-mapped UART: register offsets inside the
// three-word window, STATUS bit positions, transmitter state encoding and a
// helper that assembles the STATUS word.
package mmio_uart_pkg;

  // Byte offsets of the registers relative to BASE_ADDR (address[1:0] ignored).
  localparam logic [3:0] OFF_DATA   = 4'h0;
  localparam logic [3:0] OFF_STATUS = 4'h4;
  localparam logic [3:0] OFF_CTRL   = 4'h8;

  // Size of the register window in bytes.
  localparam logic [31:0] WINDOW_BYTES = 32'd12;

  // STATUS register bit positions.
  localparam int STAT_BUSY      = 0;
  localparam int STAT_FULL      = 1;
  localparam int STAT_EMPTY     = 2;
  localparam int STAT_OVF       = 3;
  localparam int STAT_COUNT_LSB = 8;

  // CTRL register bit positions.
  localparam int CTRL_IRQ_EN = 0;

  // Transmitter states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  // Assemble the STATUS read value from its individual fields.
  function automatic logic [31:0] status_word(input logic       busy,
                                              input logic       full,
                                              input logic       empty,
                                              input logic       ovf,
                                              input logic [7:0] count);
    logic [31:0] w;
    w                        = '0;
    w[STAT_BUSY]             = busy;
    w[STAT_FULL]             = full;
    w[STAT_EMPTY]            = empty;
    w[STAT_OVF]              = ovf;
    w[STAT_COUNT_LSB +: 8]   = count;
    return w;
  endfunction

endpackage

// File: rtl/mmio_uart_tx_sync_fifo.sv
// Synchronous single-clock FIFO with push/pop/full/empty/count. Pointers carry
// one extra wrap bit so full and empty are told apart by the MSB difference.
// Pushes to a full FIFO and pops from an empty one are ignored. The read data
// is the current head entry, valid whenever empty is low (show-ahead).
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count   = wr_ptr - rd_ptr;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr[AW-1:0]];

  // Store pushed entries.
  // NOTE: the storage array has no reset; stale contents are never visible
  // because the pointers, which are reset, decide what is valid.
  always_ff @(posedge clock) begin
    if (do_push) begin
      mem[wr_ptr[AW-1:0]] <= wdata;
    end
  end

  // Advance the read and write pointers.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter. CPU stores to DATA queue bytes in a FIFO;
// a four-state FSM serialises them 8N1, LSB first, on tx. STATUS exposes
// busy/full/empty/sticky overflow/count. Optional build macro
// MMIO_UART_TX_IRQ_EN adds the CTRL register (irq_en) and a registered irq
// output; without it offset +8 reads 0 and ignores writes.
module mmio_uart_tx
  import mmio_uart_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_1000,
  parameter int          CLKS_PER_BIT = 104,
  parameter int          FIFO_DEPTH   = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        mem_write,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        sel,
  output logic        tx
`ifdef MMIO_UART_TX_IRQ_EN
  ,
  output logic        irq
`endif
);

  localparam int FIFO_AW = $clog2(FIFO_DEPTH);
  localparam int CNT_W   = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  logic [31:0] off;
  logic [3:0]  reg_off;
  logic        wr_data;
  logic        wr_status;
  logic        wr_ctrl;

  assign off       = address - BASE_ADDR;
  assign sel       = (off < WINDOW_BYTES);
  assign reg_off   = {off[3:2], 2'b00};
  assign wr_data   = mem_write && sel && (reg_off == OFF_DATA);
  assign wr_status = mem_write && sel && (reg_off == OFF_STATUS);
  assign wr_ctrl   = mem_write && sel && (reg_off == OFF_CTRL);

  // ---------------------------------------------------------------------------
  // TX FIFO
  // ---------------------------------------------------------------------------
  logic             fifo_pop;
  logic [7:0]       fifo_rdata;
  logic             fifo_full;
  logic             fifo_empty;
  logic [FIFO_AW:0] fifo_count;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (wr_data),
    .pop   (fifo_pop),
    .wdata (write_data[7:0]),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // ---------------------------------------------------------------------------
  // Sticky overflow and optional interrupt enable
  // ---------------------------------------------------------------------------
  logic overflow;

  // Overflow sets when a push meets a full FIFO (pre-edge), clears on a STATUS write.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      overflow <= 1'b0;
    end else if (wr_data && fifo_full) begin
      overflow <= 1'b1;
    end else if (wr_status) begin
      overflow <= 1'b0;
    end
  end

`ifdef MMIO_UART_TX_IRQ_EN
  logic irq_en;

  // CTRL register: holds the interrupt enable.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      irq_en <= 1'b0;
    end else if (wr_ctrl) begin
      irq_en <= write_data[CTRL_IRQ_EN];
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Transmitter FSM
  // ---------------------------------------------------------------------------
  tx_state_t        state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [2:0]       bit_idx, bit_idx_n;
  logic [7:0]       shift, shift_n;
  logic             tx_n;
  logic             cnt_last;
  logic             busy;

  assign cnt_last = (cnt == CNT_LAST);
  assign busy     = (state != IDLE);

  // State, baud counter, bit index, shift register and registered tx.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
      tx      <= 1'b1;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bit_idx <= bit_idx_n;
      shift   <= shift_n;
      tx      <= tx_n;
    end
  end

  // Next-state logic; tx is derived from the next state so the pin is a clean flop.
  // NOTE: every output of this block is given a default first so no path
  // leaves a signal unassigned, which would infer a latch.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    bit_idx_n = bit_idx;
    shift_n   = shift;
    fifo_pop  = 1'b0;
    tx_n      = 1'b1;

    unique case (state)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_n  = fifo_rdata;
          cnt_n    = '0;
          state_n  = START;
        end
      end
      START: begin
        if (cnt_last) begin
          cnt_n     = '0;
          bit_idx_n = '0;
          state_n   = DATA;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      DATA: begin
        if (cnt_last) begin
          cnt_n = '0;
          if (bit_idx == 3'd7) begin
            state_n = STOP;
          end else begin
            bit_idx_n = bit_idx + 3'd1;
            shift_n   = {1'b0, shift[7:1]};
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      STOP: begin
        if (cnt_last) begin
          cnt_n   = '0;
          state_n = IDLE;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase

    unique case (state_n)
      START:   tx_n = 1'b0;
      DATA:    tx_n = shift_n[0];
      default: tx_n = 1'b1;
    endcase
  end

`ifdef MMIO_UART_TX_IRQ_EN
  // Interrupt: enabled, nothing queued and the line idle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      irq <= 1'b0;
    end else begin
      irq <= irq_en && fifo_empty && !busy;
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Register read mux (combinational from address)
  // ---------------------------------------------------------------------------
  // Select the addressed register; anything outside the window reads 0.
  always_comb begin
    read_data = '0;
    if (sel) begin
      unique case (reg_off)
        OFF_STATUS: read_data = status_word(busy, fifo_full, fifo_empty, overflow,
                                            8'(fifo_count));
`ifdef MMIO_UART_TX_IRQ_EN
        OFF_CTRL:   read_data = {31'b0, irq_en};
`endif
        default:    read_data = '0;
      endcase
    end
  end

  // Upper store-data bits and the CTRL strobe in the default build carry no meaning.
  logic unused_inputs;
  assign unused_inputs = ^{1'b0, write_data[31:8], wr_ctrl};

endmodule
